// File: rtl/mask_sbox_ctrl.sv
// Masks a block byte-serially with an LFSR keystream.
// Ports: clk/rst, in_* block, seed_* reseed, out_* result, threshold, busy.
module mask_sbox_ctrl #(
  parameter int          NBYTES = 16,
  parameter logic [63:0] SEED   = 64'h0000_0000_0000_02BA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8*NBYTES-1:0]   in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [63:0]           seed_data,
  input  logic                  seed_valid,
  output logic                  seed_ready,
  output logic [8*NBYTES-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            threshold,
  output logic                  busy
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e              state_q;
  logic [63:0]         lfsr_q;
  logic [IW-1:0]       idx_q;
  logic [8*NBYTES-1:0] blk_q;
  logic [8*NBYTES-1:0] out_q;
  logic                out_valid_q;
  logic                busy_q;

  logic                seed_hs;
  logic                in_hs;
  logic [63:0]         lfsr_step;
  logic [63:0]         seed_load;

  assign lfsr_step = {lfsr_q[62:0], lfsr_q[1] ^ lfsr_q[2]};
  // an all-zero seed would lock the LFSR at zero forever
  assign seed_load = (seed_data == 64'd0) ? SEED : seed_data;

  // reseed wins over a simultaneous block
  assign seed_hs = (state_q == IDLE) && seed_valid;
  assign in_hs   = (state_q == IDLE) && !seed_valid && in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED;
      idx_q       <= '0;
      blk_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (seed_hs) begin
            lfsr_q <= seed_load;
          end else if (in_hs) begin
            blk_q   <= in_data;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          out_q[{idx_q, 3'b000} +: 8] <=
            blk_q[{idx_q, 3'b000} +: 8] ^ lfsr_q[7:0];
          lfsr_q <= lfsr_step;
          idx_q  <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign seed_ready = !busy_q;
  assign in_ready   = !busy_q && !seed_valid;
  assign out_valid  = out_valid_q;
  assign out_data   = out_q;
  assign threshold  = lfsr_q[7:0];
  assign busy       = busy_q;

endmodule

// File: tb/tb_mask_sbox_ctrl.sv
// Scoreboard bench for mask_sbox_ctrl.
// Stimulus pushes expected blocks; a monitor pops them on out handshakes.
module tb_mask_sbox_ctrl;

  localparam int          NB   = 16;
  localparam int          W    = 8 * NB;
  localparam logic [63:0] SEED = 64'h0000_0000_0000_02BA;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  seed_data;
  logic         seed_valid;
  logic         seed_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   threshold;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [63:0]  m_lfsr;
  logic [W-1:0] expq[$];

  mask_sbox_ctrl #(.NBYTES(NB), .SEED(SEED)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .seed_data (seed_data),
    .seed_valid(seed_valid),
    .seed_ready(seed_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .threshold (threshold),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] step(input logic [63:0] l);
    return {l[62:0], l[1] ^ l[2]};
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // model: mask a block with the running keystream
  task automatic push_exp(input logic [W-1:0] d);
    logic [W-1:0] e;
    e = '0;
    for (int i = 0; i < NB; i++) begin
      e[8*i +: 8] = d[8*i +: 8] ^ m_lfsr[7:0];
      m_lfsr = step(m_lfsr);
    end
    expq.push_back(e);
  endtask

  // monitor: compare on every out handshake
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL mon_unexpected: got %h want none", out_data);
      end else begin
        logic [W-1:0] e;
        e = expq.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL mon_data: got %h want %h", out_data, e);
        end
      end
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // present a block until accepted; bounded
  task automatic send(input logic [W-1:0] d, input bit push);
    bit hs;
    hs = 0;
    in_data  = d;
    in_valid = 1'b1;
    for (int n = 0; n < 60 && !hs; n++) begin
      @(negedge clk);
      hs = in_ready;
      cyc();
    end
    in_valid = 1'b0;
    checks++;
    if (!hs) begin
      errors++;
      $display("FAIL send_accept: got 0 want 1");
    end else if (push) begin
      push_exp(d);
    end
  endtask

  // cycles from handshake until out_valid; 0 means timeout
  task automatic wait_out(output int n);
    n = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (out_valid) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic [W-1:0] hold;
    logic [7:0]   th;
    int           lat;

    rst        = 1'b1;
    in_data    = '0;
    in_valid   = 1'b0;
    seed_data  = '0;
    seed_valid = 1'b0;
    out_ready  = 1'b1;
    m_lfsr     = SEED;
    cyc();
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_seed_ready", W'(seed_ready), W'(1));
    chk("rst_threshold", W'(threshold), W'(8'hBA));
    chk("rst_out_data", out_data, W'(0));
    cyc();

    // zero block: latency and first mask bytes
    send('0, 1);
    wait_out(lat);
    chk("latency", W'(lat), W'(17));
    chk("z_byte0", W'(out_data[7:0]), W'(8'hBA));
    chk("z_byte1", W'(out_data[15:8]), W'(8'h75));
    d1 = out_data;
    cyc();

    // same block again continues the stream
    send('0, 1);
    wait_out(lat);
    d2 = out_data;
    checks++;
    if (d1 === d2) begin
      errors++;
      $display("FAIL repeat_differs: got %h want not %h", d2, d1);
    end
    cyc();

    send({NB{8'hFF}}, 1);
    wait_out(lat);
    cyc();
    send(128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 1);
    wait_out(lat);
    cyc();

    // zero reseed collides with a block: reseed wins
    seed_data  = '0;
    seed_valid = 1'b1;
    in_data    = 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0F0F;
    in_valid   = 1'b1;
    @(negedge clk);
    chk("sd_in_ready", W'(in_ready), W'(0));
    chk("sd_seed_ready", W'(seed_ready), W'(1));
    cyc();
    seed_valid = 1'b0;
    m_lfsr     = SEED;
    @(negedge clk);
    chk("sd_threshold", W'(threshold), W'(8'hBA));
    chk("sd_busy", W'(busy), W'(0));
    chk("sd_in_ready2", W'(in_ready), W'(1));
    cyc();
    in_valid = 1'b0;
    push_exp(in_data);
    @(negedge clk);
    chk("sd_accepted", W'(busy), W'(1));
    wait_out(lat);
    checks++;
    if (lat == 0) begin
      errors++;
      $display("FAIL sd_out: got timeout want out_valid");
    end
    cyc();

    // back-pressure in DONE
    out_ready = 1'b0;
    send(128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10, 1);
    wait_out(lat);
    hold     = out_data;
    th       = threshold;
    in_data  = '1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      @(negedge clk);
      chk("st_valid", W'(out_valid), W'(1));
      chk("st_data", out_data, hold);
      chk("st_thr", W'(threshold), W'(th));
      chk("st_in_ready", W'(in_ready), W'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc();
    cyc();

    // reset while idx=7 aborts the block
    send(128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0, 0);
    for (int i = 0; i < 7; i++) cyc();
    rst = 1'b1;
    cyc();
    rst    = 1'b0;
    m_lfsr = SEED;
    @(negedge clk);
    chk("ab_busy", W'(busy), W'(0));
    chk("ab_out_valid", W'(out_valid), W'(0));
    chk("ab_threshold", W'(threshold), W'(8'hBA));
    chk("ab_out_data", out_data, W'(0));
    cyc();

    // reseed request during RUN is ignored
    send(128'h55AA_55AA_1111_2222_3333_4444_5555_6666, 1);
    seed_data  = 64'hDEAD_BEEF_1234_5678;
    seed_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rs_seed_ready", W'(seed_ready), W'(0));
      cyc();
    end
    seed_valid = 1'b0;
    wait_out(lat);
    cyc();
    send(128'h0, 1);
    wait_out(lat);
    cyc();

    for (int i = 0; i < 50 && expq.size() != 0; i++) cyc();
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d want 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
